// File: rtl/mano_seq_ctrl.sv
// Multi-cycle fetch/indirect/execute sequencer for the basic-computer CPU.
// Optional retired-instruction counter: define MANO_SEQ_INSN_CNT_EN.
module mano_seq_ctrl #(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [AWIDTH-1:0] i_start_pc,
  output logic              o_mem_req,
  output logic [AWIDTH-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic [DWIDTH-1:0] o_ir,
  output logic [AWIDTH-1:0] o_pc,
  output logic [AWIDTH-1:0] o_ea,
  output logic              o_execute,
  input  logic              i_ex_done,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_err
`ifdef MANO_SEQ_INSN_CNT_EN
  ,
  output logic [31:0]       o_insn_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IND,
    S_EXEC, S_WAIT_EX, S_HALT, S_ERR
  } state_t;

  state_t state, state_d;
  logic [AWIDTH-1:0] pc, pc_d, ea, ea_d;
  logic [DWIDTH-1:0] ir, ir_d;
  logic [CW-1:0] wcnt, wcnt_d;

  logic i_bit;
  logic [2:0] op;
  logic [AWIDTH-1:0] addr;

  assign i_bit = ir[DWIDTH-1];
  assign op    = ir[DWIDTH-2:DWIDTH-4];
  assign addr  = ir[AWIDTH-1:0];

  assign o_pc = pc;
  assign o_ir = ir;
  assign o_ea = ea;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      ea    <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ir    <= ir_d;
      ea    <= ea_d;
      wcnt  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    ea_d       = ea;
    wcnt_d     = wcnt;
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_execute  = 1'b0;
    o_busy     = 1'b1;
    o_halted   = 1'b0;
    o_err      = 1'b0;
    unique case (state)
      S_IDLE, S_HALT, S_ERR: begin
        o_busy   = 1'b0;
        o_halted = (state == S_HALT);
        o_err    = (state == S_ERR);
        if (i_start) begin
          pc_d    = i_start_pc;
          wcnt_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = pc;
        if (i_mem_ack) begin
          ir_d    = i_mem_rdata;
          pc_d    = pc + 1'b1;
          state_d = S_DECODE;
        end else if (wcnt == CW'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      S_DECODE: begin
        ea_d = addr;
        if (op != 3'd7) begin
          wcnt_d  = '0;
          state_d = i_bit ? S_IND : S_EXEC;
        end else if (i_bit) begin
          state_d = S_ERR;
        end else if (addr == AWIDTH'(1)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_IND: begin
        o_mem_req  = 1'b1;
        o_mem_addr = addr;
        if (i_mem_ack) begin
          ea_d    = i_mem_rdata[AWIDTH-1:0];
          state_d = S_EXEC;
        end else if (wcnt == CW'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      S_EXEC: begin
        wcnt_d = '0;
        // BUN is resolved here; the datapath never sees it
        if (op == 3'd4) begin
          pc_d    = ea;
          state_d = S_FETCH;
        end else begin
          o_execute = 1'b1;
          state_d   = i_ex_done ? S_FETCH : S_WAIT_EX;
        end
      end
      S_WAIT_EX: begin
        wcnt_d = '0;
        if (i_ex_done) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MANO_SEQ_INSN_CNT_EN
  logic retire;
  assign retire = (state == S_EXEC || state == S_WAIT_EX) &&
                  (state_d == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_insn_cnt <= '0;
    else if (retire) o_insn_cnt <= o_insn_cnt + 32'd1;
  end
`endif

endmodule
